seg_scan: RTL and testbench



---
 rtl/seg_scan.sv | 251 +++++++++++++++++++++++++
 tb/tb_seg_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// ============================================================================
// seg_scan -- time-multiplexed 4-digit common-anode seven-segment driver
//
// Purpose:
//   Scans four hex digits one at a time. A prescaler turns the MHz system
//   clock into a slow tick; the scan FSM spends ON_TICKS ticks driving one
//   digit and BLANK_TICKS ticks with every anode off before moving on, which
//   suppresses ghosting between neighbouring digits. New display data is
//   parked in a shadow register and only copied to the displayed (active)
//   register at a frame boundary, so a digit never shows a torn value.
//
// Parameters:
//   DIV          prescaler terminal count; one tick every DIV+1 cycles (<=8191)
//   ON_TICKS     ticks each digit is driven (1..15)
//   BLANK_TICKS  ticks with all anodes off between digits (1..15)
//
// Ports:
//   MHz      in   system clock, single clock domain
//   rst      in   asynchronous active-high reset
//   load     in   1-cycle strobe, captures value/dp
//   value    in   [15:0] four hex nibbles, [3:0] = digit0 (rightmost)
//   dp       in   [3:0] decimal points, 1 = lit, dp[k] belongs to digit k
//   an       out  [3:0] anode enables, active-low, an[k] drives digit k
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   seg_dp   out  decimal point segment, active-low
//   frame    out  1-cycle pulse in the cycle digit3's blank phase ends
//   pending  out  shadow data is waiting for the next frame boundary
//
// Build option:
//   SEG_LZB_EN  when defined, leading zeros (digits 1..3) are kept dark unless
//               their decimal point is lit. Digit 0 always shows.
// ============================================================================
module seg_scan #(
    parameter int DIV         = 4999,
    parameter int ON_TICKS    = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic        MHz,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic        frame,
    output logic        pending
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    localparam logic [12:0] DIV_C      = 13'(DIV);
    localparam logic [3:0]  ON_LAST    = 4'(ON_TICKS - 1);
    localparam logic [3:0]  BLANK_LAST = 4'(BLANK_TICKS - 1);

    logic [12:0] prescale;
    logic        tick;

    state_t      state, state_nxt;
    logic [1:0]  digit, digit_nxt;
    logic [3:0]  phase_cnt, phase_nxt;
    logic        started, started_nxt;
    logic        phase_done;
    logic        boundary;

    logic [15:0] shadow_val;
    logic [3:0]  shadow_dp;
    logic [15:0] active_val;
    logic [3:0]  active_dp;

    logic [3:0]  nibble;
    logic        digit_dark;
    logic [3:0]  an_d;
    logic [6:0]  seg_d;
    logic        seg_dp_d;

    // Active-low hex decoder, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Prescaler: counts 0..DIV and wraps; tick is high in the DIV cycle.
    assign tick = (prescale == DIV_C);

    always_ff @(posedge MHz or posedge rst) begin
        if (rst) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 13'd1;
        end
    end

    // The phase counter's terminal value depends on which phase we are in.
    assign phase_done = (phase_cnt == ((state == ST_ON) ? ON_LAST : BLANK_LAST));

    // A frame boundary is leaving digit3's blank phase. The very first blank
    // after reset is not a boundary; 'started' tells the two apart.
    assign boundary = tick && phase_done && (state == ST_BLANK) && started
                      && (digit == 2'd3);

    // frame is decoded straight from registered state so it is high in the
    // same cycle the boundary update is applied; a load in that cycle can
    // then go directly to the active register.
    assign frame = boundary;

    // FSM state register: scan state, digit index, tick-in-phase count.
    always_ff @(posedge MHz or posedge rst) begin
        if (rst) begin
            state     <= ST_BLANK;
            digit     <= 2'd0;
            phase_cnt <= 4'd0;
            started   <= 1'b0;
        end else begin
            state     <= state_nxt;
            digit     <= digit_nxt;
            phase_cnt <= phase_nxt;
            started   <= started_nxt;
        end
    end

    // FSM next-state logic, advanced only on tick. The first exit from
    // BLANK after reset stays on digit 0 instead of incrementing.
    always_comb begin
        state_nxt   = state;
        digit_nxt   = digit;
        phase_nxt   = phase_cnt;
        started_nxt = started;
        if (tick) begin
            if (phase_done) begin
                phase_nxt = 4'd0;
                if (state == ST_ON) begin
                    state_nxt = ST_BLANK;
                end else begin
                    state_nxt   = ST_ON;
                    started_nxt = 1'b1;
                    if (started) begin
                        digit_nxt = digit + 2'd1;
                    end
                end
            end else begin
                phase_nxt = phase_cnt + 4'd1;
            end
        end
    end

    // Select the active nibble for the digit being scanned.
    always_comb begin
        nibble = 4'h0;
        case (digit)
            2'd0:    nibble = active_val[3:0];
            2'd1:    nibble = active_val[7:4];
            2'd2:    nibble = active_val[11:8];
            default: nibble = active_val[15:12];
        endcase
    end

`ifdef SEG_LZB_EN
    // Leading-zero blanking: digit k (k>0) stays dark when nibbles k..3 are
    // all zero and its decimal point is off.
    always_comb begin
        digit_dark = 1'b0;
        case (digit)
            2'd1:    digit_dark = (active_val[15:4]  == 12'h000) && !active_dp[1];
            2'd2:    digit_dark = (active_val[15:8]  == 8'h00)   && !active_dp[2];
            2'd3:    digit_dark = (active_val[15:12] == 4'h0)    && !active_dp[3];
            default: digit_dark = 1'b0;
        endcase
    end
`else
    assign digit_dark = 1'b0;
`endif

    // FSM output logic: only one anode is ever enabled, and only in ON.
    always_comb begin
        an_d     = 4'b1111;
        seg_d    = 7'b1111111;
        seg_dp_d = 1'b1;
        if ((state == ST_ON) && !digit_dark) begin
            an_d        = 4'b1111;
            an_d[digit] = 1'b0;
            seg_d       = hex7(nibble);
            seg_dp_d    = ~active_dp[digit];
        end
    end

    // Output register: pins follow the FSM state one cycle later and are
    // glitch-free.
    always_ff @(posedge MHz or posedge rst) begin
        if (rst) begin
            an     <= 4'b1111;
            seg    <= 7'b1111111;
            seg_dp <= 1'b1;
        end else begin
            an     <= an_d;
            seg    <= seg_d;
            seg_dp <= seg_dp_d;
        end
    end

    // Shadow/active data path. Loads park in the shadow register until the
    // frame boundary; a load landing exactly on the boundary bypasses the
    // shadow so it is not delayed by a whole frame. Reset discards anything
    // still pending.
    always_ff @(posedge MHz or posedge rst) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                active_val <= value;
                active_dp  <= dp;
            end else if (pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            pending <= 1'b0;
        end else if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp;
            pending    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// ============================================================================
// tb_seg_scan -- directed testbench for seg_scan
//
// Runs the scanner with DIV=3, ON_TICKS=2, BLANK_TICKS=1, giving 12 cycles
// per digit and 48 per frame. edge_count numbers rising edges since the last
// reset release; expected outputs are tied to those edge numbers:
//   state after edge m: ON digit0 [4,11], BLANK [12,15], ON digit1 [16,23] ...
//   digit3 blank ends with a frame pulse in the cycle after edge 51, 99, ...
//   outputs lag state by one edge, so digit k of frame f (f>=1) is lit after
//   edges 53+48(f-1)+12k .. 60+48(f-1)+12k.
// ============================================================================
module tb_seg_scan;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic        MHz = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        seg_dp;
    logic        frame;
    logic        pending;

    int checks = 0;
    int errors = 0;
    int edge_count;

    seg_scan #(
        .DIV         (3),
        .ON_TICKS    (2),
        .BLANK_TICKS (1)
    ) dut (
        .MHz     (MHz),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .dp      (dp),
        .an      (an),
        .seg     (seg),
        .seg_dp  (seg_dp),
        .frame   (frame),
        .pending (pending)
    );

    // 100 MHz-style free-running clock.
    always #5 MHz = ~MHz;

    // Rising edges since reset release.
    always @(posedge MHz or posedge rst) begin
        if (rst) begin
            edge_count <= 0;
        end else begin
            edge_count <= edge_count + 1;
        end
    end

    // Hard stop in case something wedges the stimulus process.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after rising edge n (counted from reset release).
    task automatic waitEdge(input int n);
        while (edge_count < n) begin
            @(posedge MHz);
            #1;
        end
    endtask

    // Pulse load for one cycle so it is captured on edge n.
    task automatic applyStimulus(input int n, input logic [15:0] v, input logic [3:0] d);
        waitEdge(n - 1);
        value = v;
        dp    = d;
        load  = 1'b1;
        waitEdge(n);
        load  = 1'b0;
    endtask

    // Check anode, segment and decimal-point pins after edge n.
    task automatic checkDigit(input string tag, input int n, input logic [3:0] exp_an,
                              input logic [6:0] exp_seg, input logic exp_dp);
        waitEdge(n);
        checkOutput({tag, "_an"},  {12'h0, an},     {12'h0, exp_an});
        checkOutput({tag, "_seg"}, {9'h0, seg},     {9'h0, exp_seg});
        checkOutput({tag, "_dp"},  {15'h0, seg_dp}, {15'h0, exp_dp});
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge MHz);
        #1;
        checkOutput("rst_an",      {12'h0, an},      16'h000F);
        checkOutput("rst_seg",     {9'h0, seg},      {9'h0, SEG_OFF});
        checkOutput("rst_seg_dp",  {15'h0, seg_dp},  16'h0001);
        checkOutput("rst_frame",   {15'h0, frame},   16'h0000);
        checkOutput("rst_pending", {15'h0, pending}, 16'h0000);
        @(negedge MHz);
        rst = 1'b0;

        // First frame after reset: all zeros, anodes walk with blank gaps.
        waitEdge(4);
        checkOutput("init_blank_an", {12'h0, an}, 16'h000F);
        checkDigit("f0_d0_first", 5, 4'b1110, SEG_0, 1'b1);
        checkDigit("f0_d0_last", 12, 4'b1110, SEG_0, 1'b1);
        checkDigit("f0_gap0", 13, 4'b1111, SEG_OFF, 1'b1);
        checkDigit("f0_d1", 17, 4'b1101, SEG_0, 1'b1);
        checkDigit("f0_d2", 29, 4'b1011, SEG_0, 1'b1);
        checkDigit("f0_d3", 41, 4'b0111, SEG_0, 1'b1);
        checkDigit("f0_gap3", 49, 4'b1111, SEG_OFF, 1'b1);
        waitEdge(50);
        checkOutput("frame_early", {15'h0, frame}, 16'h0000);
        waitEdge(51);
        checkOutput("frame_first", {15'h0, frame}, 16'h0001);
        waitEdge(52);
        checkOutput("frame_width", {15'h0, frame}, 16'h0000);

        // Mid-frame load of 1A8F / dp=0100: held until the next boundary.
        applyStimulus(60, 16'h1A8F, 4'b0100);
        checkOutput("load_pending", {15'h0, pending}, 16'h0001);
        checkDigit("f1_d1_old", 66, 4'b1101, SEG_0, 1'b1);
        waitEdge(99);
        checkOutput("frame_second", {15'h0, frame}, 16'h0001);
        checkOutput("pending_hold", {15'h0, pending}, 16'h0001);
        waitEdge(100);
        checkOutput("pending_clear", {15'h0, pending}, 16'h0000);
        checkDigit("f2_d0", 102, 4'b1110, SEG_F, 1'b1);
        checkDigit("f2_d1", 114, 4'b1101, SEG_8, 1'b1);
        checkDigit("f2_d2", 126, 4'b1011, SEG_A, 1'b0);
        checkDigit("f2_d3", 138, 4'b0111, SEG_1, 1'b1);

        // Two loads in one frame: the second one wins.
        applyStimulus(150, 16'h1111, 4'b0000);
        checkDigit("f3_d0_old", 152, 4'b1110, SEG_F, 1'b1);
        applyStimulus(160, 16'h2222, 4'b0000);
        checkOutput("twoload_pending", {15'h0, pending}, 16'h0001);
        checkDigit("f4_d0", 198, 4'b1110, SEG_2, 1'b1);
        checkDigit("f4_d1", 210, 4'b1101, SEG_2, 1'b1);
        checkDigit("f4_d2", 222, 4'b1011, SEG_2, 1'b1);
        checkDigit("f4_d3", 234, 4'b0111, SEG_2, 1'b1);

        // Load coincident with the frame pulse goes straight to the display.
        waitEdge(243);
        checkOutput("coinc_frame", {15'h0, frame}, 16'h0001);
        value = 16'h0005;
        dp    = 4'b0000;
        load  = 1'b1;
        waitEdge(244);
        load  = 1'b0;
        checkOutput("coinc_pending", {15'h0, pending}, 16'h0000);
        checkDigit("f5_d0", 246, 4'b1110, SEG_5, 1'b1);
`ifdef SEG_LZB_EN
        checkDigit("f5_d1_lzb", 258, 4'b1111, SEG_OFF, 1'b1);
`else
        checkDigit("f5_d1", 258, 4'b1101, SEG_0, 1'b1);
`endif

        // 0005 with digit3's point lit.
        applyStimulus(260, 16'h0005, 4'b1000);
`ifdef SEG_LZB_EN
        checkDigit("f5_d3_lzb", 282, 4'b1111, SEG_OFF, 1'b1);
`else
        checkDigit("f5_d3", 282, 4'b0111, SEG_0, 1'b1);
`endif
        checkDigit("f6_d0", 294, 4'b1110, SEG_5, 1'b1);
        applyStimulus(300, 16'h0105, 4'b0000);
`ifdef SEG_LZB_EN
        checkDigit("f6_d1_lzb", 306, 4'b1111, SEG_OFF, 1'b1);
        checkDigit("f6_d2_lzb", 318, 4'b1111, SEG_OFF, 1'b1);
`else
        checkDigit("f6_d1", 306, 4'b1101, SEG_0, 1'b1);
        checkDigit("f6_d2", 318, 4'b1011, SEG_0, 1'b1);
`endif
        checkDigit("f6_d3", 330, 4'b0111, SEG_0, 1'b0);

        // Reset during digit2's ON phase with shadow data pending.
        applyStimulus(360, 16'hFFFF, 4'b1111);
        checkOutput("pre_rst_pending", {15'h0, pending}, 16'h0001);
        checkDigit("f7_d2", 366, 4'b1011, SEG_1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_an",      {12'h0, an},      16'h000F);
        checkOutput("async_rst_seg",     {9'h0, seg},      {9'h0, SEG_OFF});
        checkOutput("async_rst_seg_dp",  {15'h0, seg_dp},  16'h0001);
        checkOutput("async_rst_pending", {15'h0, pending}, 16'h0000);
        @(negedge MHz);
        rst = 1'b0;

        // Scan restarts from BLANK; the discarded FFFF never shows.
        waitEdge(4);
        checkOutput("restart_blank_an", {12'h0, an}, 16'h000F);
        checkDigit("restart_d0", 5, 4'b1110, SEG_0, 1'b1);
        waitEdge(51);
        checkOutput("restart_frame", {15'h0, frame}, 16'h0001);
        checkDigit("restart_f1_d0", 54, 4'b1110, SEG_0, 1'b1);
        checkOutput("restart_pending", {15'h0, pending}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
